// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two masters and data_memory.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data_memory between the nRisc core and a DMA/loader master.
// Optional macro ARB_STATS_EN adds saturating grant and contention counters.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clock,
  input  logic              reset,
  data_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       cnt_cpu,
  output logic [15:0]       cnt_dma,
  output logic [15:0]       cnt_conflict
`endif
);

  localparam int unsigned STARVE_W = 4;
  localparam int unsigned STAT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ISSUE,
    CPU_DONE,
    DMA_ISSUE,
    DMA_DONE
  } state_t;

  state_t              state;
  logic [STARVE_W-1:0] starveCnt;
  logic                grantWe;
  logic [DATA_W-1:0]   cpuRdataQ;
  logic [DATA_W-1:0]   dmaRdataQ;
  logic                memReadQ;
  logic                memWriteQ;
  logic [ADDR_W-1:0]   memAddrQ;
  logic [DATA_W-1:0]   memWdataQ;
  logic                dmaAckQ;

  logic cpuReq;
  logic arbSlot;
  logic cpuCand;
  logic dmaCand;
  logic contended;
  logic starved;
  logic grantCpu;
  logic grantDma;

  // Arbitration: the master finishing in its DONE cycle is not a candidate.
  always_comb begin
    cpuReq    = bus.cpu_rd | bus.cpu_wr;
    arbSlot   = (state == IDLE) || (state == CPU_DONE) || (state == DMA_DONE);
    cpuCand   = cpuReq && (state != CPU_DONE);
    dmaCand   = bus.dma_req && (state != DMA_DONE);
    contended = arbSlot && cpuCand && dmaCand;
    starved   = (starveCnt == STARVE_W'(STARVE_LIMIT));
    grantDma  = arbSlot && dmaCand && (!cpuCand || starved);
    grantCpu  = arbSlot && cpuCand && !grantDma;
  end

  // Access sequencer; memory strobes/address are loaded at grant so they are live only in ISSUE.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state     <= IDLE;
      starveCnt <= '0;
      grantWe   <= 1'b0;
      cpuRdataQ <= '0;
      dmaRdataQ <= '0;
      memReadQ  <= 1'b0;
      memWriteQ <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      dmaAckQ   <= 1'b0;
    end else begin
      memReadQ  <= 1'b0;
      memWriteQ <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      dmaAckQ   <= 1'b0;

      if (state == CPU_DONE && !grantWe) cpuRdataQ <= bus.mem_rdata;
      if (state == DMA_DONE && !grantWe) dmaRdataQ <= bus.mem_rdata;

      case (state)
        CPU_ISSUE: state <= CPU_DONE;
        DMA_ISSUE: begin
          state   <= DMA_DONE;
          dmaAckQ <= 1'b1;
        end
        default:   state <= IDLE;
      endcase

      if (grantCpu) begin
        state     <= CPU_ISSUE;
        grantWe   <= bus.cpu_wr;
        memReadQ  <= ~bus.cpu_wr;
        memWriteQ <= bus.cpu_wr;
        memAddrQ  <= bus.cpu_addr;
        memWdataQ <= bus.cpu_wdata;
        if (contended && starveCnt != {STARVE_W{1'b1}}) starveCnt <= starveCnt + STARVE_W'(1);
      end

      if (grantDma) begin
        state     <= DMA_ISSUE;
        grantWe   <= bus.dma_we;
        memReadQ  <= ~bus.dma_we;
        memWriteQ <= bus.dma_we;
        memAddrQ  <= bus.dma_addr;
        memWdataQ <= bus.dma_wdata;
        starveCnt <= '0;
      end
    end
  end

  // Read data is forwarded straight from memory in DONE so the core can consume it that cycle.
  assign bus.cpu_rdata = (state == CPU_DONE && !grantWe) ? bus.mem_rdata : cpuRdataQ;
  assign bus.dma_rdata = (state == DMA_DONE && !grantWe) ? bus.mem_rdata : dmaRdataQ;
  assign bus.cpu_stall = !reset && cpuReq && (state != CPU_DONE);
  assign bus.dma_ack   = dmaAckQ;
  assign bus.mem_read  = memReadQ;
  assign bus.mem_write = memWriteQ;
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_wdata = memWdataQ;

`ifdef ARB_STATS_EN
  always_ff @(posedge Clock) begin
    if (reset) begin
      cnt_cpu      <= '0;
      cnt_dma      <= '0;
      cnt_conflict <= '0;
    end else begin
      if (grantCpu && cnt_cpu != {STAT_W{1'b1}}) cnt_cpu <= cnt_cpu + STAT_W'(1);
      if (grantDma && cnt_dma != {STAT_W{1'b1}}) cnt_dma <= cnt_dma + STAT_W'(1);
      if (contended && cnt_conflict != {STAT_W{1'b1}}) cnt_conflict <= cnt_conflict + STAT_W'(1);
    end
  end
`endif

endmodule
